otter_io_timer: RTL and testbench

//  Memory-mapped interval timer on the OTTER IOBUS; it is the responder side of the MCU's MMIO port.

---
 rtl/otter_io_pkg.sv | 26 ++
 rtl/io_prescaler.sv | 40 ++++
 rtl/otter_io_timer.sv | 141 ++++++++++++++
 tb/tb_otter_io_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// otter_io_pkg: shared definitions for the OTTER IOBUS interval timer.
//   - byte offsets of the five registers and their word indices
//   - CTRL bit positions
//   - timer state encoding
package otter_io_pkg;

  localparam logic [31:0] CTRL_OFS     = 32'h0000_0000;
  localparam logic [31:0] PRESCALE_OFS = 32'h0000_0004;
  localparam logic [31:0] PERIOD_OFS   = 32'h0000_0008;
  localparam logic [31:0] COUNT_OFS    = 32'h0000_000C;
  localparam logic [31:0] STATUS_OFS   = 32'h0000_0010;

  // Word indices, compared against (IOBUS_ADDR[31:2] - BASE_ADDR[31:2]).
  localparam logic [29:0] CTRL_IDX     = CTRL_OFS[31:2];
  localparam logic [29:0] PRESCALE_IDX = PRESCALE_OFS[31:2];
  localparam logic [29:0] PERIOD_IDX   = PERIOD_OFS[31:2];
  localparam logic [29:0] COUNT_IDX    = COUNT_OFS[31:2];
  localparam logic [29:0] STATUS_IDX   = STATUS_OFS[31:2];

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_RELOAD = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_t;

endpackage

// File: rtl/io_prescaler.sv
// io_prescaler: clock divider for the interval timer.
//   CLK    in   system clock
//   RESET  in   synchronous active-high reset
//   clr    in   force the divider count back to 0
//   run    in   count only while high
//   div    in   terminal value; tick fires when the count equals div
//   tick   out  one-cycle tick, every div+1 running cycles
module io_prescaler (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        run,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// otter_io_timer: memory-mapped interval timer on the OTTER IOBUS.
//   CLK         in   system clock
//   RESET       in   synchronous active-high reset
//   IOBUS_ADDR  in   byte address; bits [1:0] ignored
//   IOBUS_OUT   in   write data
//   IOBUS_WR    in   one-cycle write strobe
//   IOBUS_IN    out  combinational read data, 0 when unmapped
//   INTR        out  interrupt pulse, INTR_WIDTH cycles per expiry
//
// state | meaning
// IDLE  | disabled; count and prescaler frozen
// RUN   | counting down on prescaler ticks
// DONE  | one-shot expired; count held at 0, EN still reads 1
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1120_0000,
  parameter int          INTR_WIDTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pulse_q, pulse_d;
  logic        expired_q, expired_d;
  tmr_state_t  state_q, state_d;

  logic [29:0] word_ofs;
  logic        wr_ctrl, wr_prescale, wr_period, wr_count, wr_status;
  logic        tick, presc_clr;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^IOBUS_ADDR[1:0];

  // Addresses below the base wrap to a large offset and miss.
  assign word_ofs    = IOBUS_ADDR[31:2] - BASE_ADDR[31:2];
  assign wr_ctrl     = IOBUS_WR && (word_ofs == CTRL_IDX);
  assign wr_prescale = IOBUS_WR && (word_ofs == PRESCALE_IDX);
  assign wr_period   = IOBUS_WR && (word_ofs == PERIOD_IDX);
  assign wr_count    = IOBUS_WR && (word_ofs == COUNT_IDX);
  assign wr_status   = IOBUS_WR && (word_ofs == STATUS_IDX);

  assign presc_clr = (wr_ctrl && IOBUS_OUT[CTRL_EN]) || wr_count;

  io_prescaler u_presc (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (presc_clr),
    .run   (state_q == RUN),
    .div   (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    IOBUS_IN = '0;
    case (word_ofs)
      CTRL_IDX:     IOBUS_IN = {29'd0, ctrl_q};
      PRESCALE_IDX: IOBUS_IN = {16'd0, prescale_q};
      PERIOD_IDX:   IOBUS_IN = period_q;
      COUNT_IDX:    IOBUS_IN = count_q;
      STATUS_IDX:   IOBUS_IN = {31'd0, expired_q};
      default:      IOBUS_IN = '0;
    endcase
  end

  always_comb begin
    ctrl_d     = wr_ctrl     ? IOBUS_OUT[2:0]  : ctrl_q;
    prescale_d = wr_prescale ? IOBUS_OUT[15:0] : prescale_q;
    period_d   = wr_period   ? IOBUS_OUT       : period_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
    pulse_d   = (pulse_q != '0) ? pulse_q - 32'd1 : pulse_q;

    if (wr_status && IOBUS_OUT[0]) begin
      expired_d = 1'b0;
    end

    // CTRL and COUNT writes take priority over a tick in the same cycle,
    // so an expiry coinciding with them is dropped.
    if (wr_ctrl) begin
      if (IOBUS_OUT[CTRL_EN]) begin
        count_d = period_q;
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else if (wr_count) begin
      count_d = IOBUS_OUT;
    end else if (state_q == RUN && tick) begin
      if (count_q == '0) begin
        expired_d = 1'b1;
        if (ctrl_q[CTRL_IE]) begin
          pulse_d = 32'(INTR_WIDTH);
        end
        if (ctrl_q[CTRL_RELOAD]) begin
          count_d = period_q;
        end else begin
          state_d = DONE;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      period_q   <= '0;
      count_q    <= '0;
      pulse_q    <= '0;
      expired_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      count_q    <= count_d;
      pulse_q    <= pulse_d;
      expired_q  <= expired_d;
      state_q    <= state_d;
    end
  end

  assign INTR = (pulse_q != '0);

endmodule

// File: tb/tb_otter_io_timer.sv
module tb_otter_io_timer;

  localparam logic [31:0] BASE     = 32'h1120_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_PRESC  = BASE + 32'h04;
  localparam logic [31:0] A_PERIOD = BASE + 32'h08;
  localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] A_PAST   = BASE + 32'h14;
  localparam logic [31:0] A_FAR    = BASE + 32'h100;
  localparam logic [31:0] A_BELOW  = BASE - 32'h4;
  localparam logic [31:0] A_IDLE   = BASE + 32'h200;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = A_IDLE;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  logic        chk_req = 1'b0;
  logic [31:0] exp_d_q[$];
  logic        exp_i_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;

  otter_io_timer #(.BASE_ADDR(BASE), .INTR_WIDTH(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  // Monitor: compares IOBUS_IN and INTR against the oldest queued expectation.
  always @(negedge CLK) begin
    if (chk_req) begin
      if (exp_d_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: check requested with empty queue");
      end else begin
        logic [31:0] ed;
        logic        ei;
        string       tg;
        ed = exp_d_q.pop_front();
        ei = exp_i_q.pop_front();
        tg = tag_q.pop_front();
        total++;
        if (IOBUS_IN !== ed) begin
          bad++;
          $display("FAIL %s data: got %h want %h", tg, IOBUS_IN, ed);
        end
        total++;
        if (INTR !== ei) begin
          bad++;
          $display("FAIL %s intr: got %b want %b", tg, INTR, ei);
        end
      end
    end
  end

  task automatic cyc(input logic [31:0] addr, input logic [31:0] data, input logic we,
                     input logic chk, input logic [31:0] ed, input logic ei, input string tag);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = we;
    if (chk) begin
      exp_d_q.push_back(ed);
      exp_i_q.push_back(ei);
      tag_q.push_back(tag);
    end
    chk_req = chk;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
    chk_req  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(addr, data, 1'b1, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] ed, input logic ei, input string tag);
    cyc(addr, 32'd0, 1'b0, 1'b1, ed, ei, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(A_IDLE, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    rd(A_CTRL,   32'd0, 1'b0, "t1_ctrl");
    rd(A_PRESC,  32'd0, 1'b0, "t1_presc");
    rd(A_PERIOD, 32'd0, 1'b0, "t1_period");
    rd(A_COUNT,  32'd0, 1'b0, "t1_count");
    rd(A_STATUS, 32'd0, 1'b0, "t1_status");
    rd(A_PAST,   32'd0, 1'b0, "t1_past");

    // 2: one-shot, PERIOD=3 PRESCALE=1 -> expiry 8 edges after enable
    wr(A_PERIOD, 32'd3);
    wr(A_PRESC,  32'd1);
    wr(A_CTRL,   32'b011);
    for (int c = 0; c <= 10; c++)
      rd(A_STATUS, (c >= 8) ? 32'd1 : 32'd0, (c == 8 || c == 9), $sformatf("t2_st%0d", c));
    for (int c = 11; c <= 16; c++)
      rd(A_COUNT, 32'd0, 1'b0, $sformatf("t2_done%0d", c));
    rd(A_CTRL, 32'd3, 1'b0, "t2_ctrl_en");

    // 3: reload, PERIOD=2 PRESCALE=0 -> expiry every 3 cycles
    wr(A_STATUS, 32'd1);
    wr(A_PERIOD, 32'd2);
    wr(A_PRESC,  32'd0);
    wr(A_CTRL,   32'b111);
    for (int c = 0; c < 12; c++) begin
      if (c < 6)
        rd(A_COUNT, 32'd2 - 32'(c % 3), (c >= 3) && (c % 3 != 2), $sformatf("t3_cnt%0d", c));
      else
        rd(A_STATUS, 32'd1, (c % 3 != 2), $sformatf("t3_st%0d", c));
    end

    // 4: W1C on the expiry edge loses; one cycle later it clears
    wr(A_CTRL, 32'd0);
    idle(3);
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, 32'd0, 1'b0, "t4_cleared");
    wr(A_CTRL, 32'b111);
    rd(A_STATUS, 32'd0, 1'b0, "t4_c0");
    rd(A_STATUS, 32'd0, 1'b0, "t4_c1");
    wr(A_STATUS, 32'd1);
    cyc(A_STATUS, 32'd1, 1'b1, 1'b1, 32'd1, 1'b1, "t4_set_wins");
    rd(A_STATUS, 32'd0, 1'b1, "t4_w1c_late");
    // CTRL write on an expiry edge: no expiry recorded
    cyc(A_CTRL, 32'd0, 1'b1, 1'b1, 32'd7, 1'b0, "t4_ctrl_rd");
    rd(A_STATUS, 32'd0, 1'b0, "t4_ctrl_wins");
    rd(A_COUNT,  32'd0, 1'b0, "t4_count_held");

    // 5: unmapped writes ignored
    wr(A_FAR,   32'hDEAD_BEEF);
    wr(A_PAST,  32'hDEAD_BEEF);
    wr(A_BELOW, 32'hDEAD_BEEF);
    rd(A_CTRL,   32'd0, 1'b0, "t5_ctrl");
    rd(A_PRESC,  32'd0, 1'b0, "t5_presc");
    rd(A_PERIOD, 32'd2, 1'b0, "t5_period");
    rd(A_COUNT,  32'd0, 1'b0, "t5_count");
    rd(A_STATUS, 32'd0, 1'b0, "t5_status");
    rd(A_PAST,   32'd0, 1'b0, "t5_past");
    rd(A_FAR,    32'd0, 1'b0, "t5_far");
    // COUNT write in RUN, IE off
    wr(A_PERIOD, 32'd100);
    wr(A_PRESC,  32'd1);
    wr(A_CTRL,   32'b001);
    idle(2);
    wr(A_COUNT, 32'd5);
    for (int c = 0; c < 14; c++)
      rd(A_COUNT, (c < 10) ? 32'd5 - 32'(c / 2) : 32'd0, 1'b0, $sformatf("t5_cnt%0d", c));
    rd(A_STATUS, 32'd1, 1'b0, "t5_exp_no_ie");
    rd(A_CTRL,   32'd1, 1'b0, "t5_done_en");

    // 6: reset mid-count and mid-pulse
    wr(A_STATUS, 32'd1);
    wr(A_PERIOD, 32'd2);
    wr(A_PRESC,  32'd0);
    wr(A_CTRL,   32'b111);
    idle(3);
    rd(A_STATUS, 32'd1, 1'b1, "t6_pre_st");
    RESET = 1'b1;
    rd(A_COUNT, 32'd1, 1'b1, "t6_pre_cnt");
    RESET = 1'b0;
    rd(A_CTRL,   32'd0, 1'b0, "t6_ctrl");
    rd(A_PRESC,  32'd0, 1'b0, "t6_presc");
    rd(A_PERIOD, 32'd0, 1'b0, "t6_period");
    rd(A_COUNT,  32'd0, 1'b0, "t6_count");
    rd(A_STATUS, 32'd0, 1'b0, "t6_status");
    idle(4);
    rd(A_STATUS, 32'd0, 1'b0, "t6_idle_st");
    rd(A_COUNT,  32'd0, 1'b0, "t6_idle_cnt");

    idle(2);
    total++;
    if (exp_d_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_d_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
